aes_ctr_stream: RTL



---
 rtl/aes_ctr_stream_if.sv | 35 +++
 rtl/aes_ctr_stream.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/aes_ctr_stream_if.sv
// aes_ctr_stream_if
//   Bundles every non-clock signal of the CTR stream front end.
//   slave  : the aes_ctr_stream block (consumes iv/input stream/core result,
//            produces ready, output stream and core requests)
//   master : the environment around it (host stream source/sink plus aes core)
//   Signals: iv_load/iv (counter load), in_* (byte input, valid/ready/last),
//            out_* (byte output, valid/ready/last), aes_* (core request/result).
interface aes_ctr_stream_if;
    logic         iv_load;
    logic [127:0] iv;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;
    logic [127:0] aes_state_init;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_state_final;

    modport slave (
        input  iv_load, iv, in_valid, in_data, in_last, out_ready,
               aes_done, aes_state_final,
        output in_ready, out_valid, out_data, out_last, aes_state_init, aes_start
    );

    modport master (
        output iv_load, iv, in_valid, in_data, in_last, out_ready,
               aes_done, aes_state_final,
        input  in_ready, out_valid, out_data, out_last, aes_state_init, aes_start
    );
endinterface

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream
//   CTR-mode byte stream front end for an external aes core. Keeps a 128-bit
//   counter, sends counter blocks to the core, buffers the returned keystream
//   (one active block plus one prefetched block) and XORs it byte by byte into
//   a valid/ready byte stream. Encryption and decryption are the same operation.
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     bus   : aes_ctr_stream_if.slave (iv load, input/output byte streams,
//             aes core start/init and done/final)
module aes_ctr_stream (
    input  logic            clk,
    input  logic            rst_n,
    aes_ctr_stream_if.slave bus
);
    localparam logic [1:0] K_IDLE  = 2'd0;
    localparam logic [1:0] K_START = 2'd1;
    localparam logic [1:0] K_GAP   = 2'd2;
    localparam logic [1:0] K_BUSY  = 2'd3;

    logic [1:0]   kst_reg, kst_next;
    logic [127:0] ctr_reg;
    logic         armed_reg;
    logic         discard_reg;
    logic [127:0] cur_reg, nxt_reg;
    logic         cur_v_reg, nxt_v_reg;
    logic [3:0]   idx_reg;
    logic         out_valid_reg, out_last_reg;
    logic [7:0]   out_data_reg;
    logic         aes_start_reg;
    logic [127:0] aes_state_init_reg;

    logic         in_ready;
    logic         accept;
    logic         cur_empties;
    logic         load_cur;
    logic         core_done;
    logic         capture;
    logic         launch;
    logic [7:0]   cur_bytes [16];

    // Keystream byte k of the active block sits at bits [8k +: 8]
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            assign cur_bytes[gi] = cur_reg[8*gi +: 8];
        end
    endgenerate

    assign in_ready    = cur_v_reg & (~out_valid_reg | bus.out_ready) & ~bus.iv_load;
    assign accept      = bus.in_valid & in_ready;
    // Block ends on its 16th byte or on a message end; leftover keystream is dropped
    assign cur_empties = accept & ((idx_reg == 4'd15) | bus.in_last);
    // Prefetched block slides into the active slot on the same edge it frees up
    assign load_cur    = nxt_v_reg & (~cur_v_reg | cur_empties);
    assign core_done   = (kst_reg == K_BUSY) & bus.aes_done;
    // A result belonging to a superseded counter (discard) is never kept
    assign capture     = core_done & ~discard_reg & ~bus.iv_load;
    // At most one block in flight; a new iv is applied before the next launch
    assign launch      = (kst_reg == K_IDLE) & armed_reg & ~nxt_v_reg &
                         ~discard_reg & ~bus.iv_load;

    always_comb begin
        kst_next = kst_reg;
        case (kst_reg)
            K_IDLE:  if (launch) kst_next = K_START;
            K_START: kst_next = K_GAP;
            // done may still be high from the previous block here
            K_GAP:   kst_next = K_BUSY;
            K_BUSY:  if (bus.aes_done) kst_next = K_IDLE;
            default: kst_next = K_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kst_reg            <= K_IDLE;
            ctr_reg            <= '0;
            armed_reg          <= 1'b0;
            discard_reg        <= 1'b0;
            cur_reg            <= '0;
            nxt_reg            <= '0;
            cur_v_reg          <= 1'b0;
            nxt_v_reg          <= 1'b0;
            idx_reg            <= '0;
            out_valid_reg      <= 1'b0;
            out_last_reg       <= 1'b0;
            out_data_reg       <= '0;
            aes_start_reg      <= 1'b0;
            aes_state_init_reg <= '0;
        end else begin
            kst_reg       <= kst_next;
            aes_start_reg <= launch;
            if (launch)
                aes_state_init_reg <= ctr_reg;

            if (bus.iv_load)
                ctr_reg <= bus.iv;
            else if (launch)
                ctr_reg <= ctr_reg + 128'd1;

            armed_reg <= armed_reg | bus.iv_load;

            if (core_done)
                discard_reg <= 1'b0;
            else if (bus.iv_load && (kst_reg != K_IDLE))
                discard_reg <= 1'b1;

            if (capture)
                nxt_reg <= bus.aes_state_final;

            if (bus.iv_load) begin
                cur_v_reg <= 1'b0;
                nxt_v_reg <= 1'b0;
                idx_reg   <= '0;
            end else begin
                if (load_cur) begin
                    cur_reg   <= nxt_reg;
                    cur_v_reg <= 1'b1;
                    nxt_v_reg <= 1'b0;
                    idx_reg   <= '0;
                end else if (accept) begin
                    if (cur_empties) begin
                        cur_v_reg <= 1'b0;
                        idx_reg   <= '0;
                    end else begin
                        idx_reg <= idx_reg + 4'd1;
                    end
                end
                if (capture)
                    nxt_v_reg <= 1'b1;
            end

            // Output register holds its byte while the sink stalls
            if (accept) begin
                out_data_reg  <= bus.in_data ^ cur_bytes[idx_reg];
                out_last_reg  <= bus.in_last;
                out_valid_reg <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_reg;
    assign bus.out_data       = out_data_reg;
    assign bus.out_last       = out_last_reg;
    assign bus.aes_start      = aes_start_reg;
    assign bus.aes_state_init = aes_state_init_reg;
endmodule
